regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
- Parametrised successor to the single-cycle MIPS register file.
- Generalises width, depth and number of read ports, hard-wires register 0 to zero, and adds an after-reset hardware clear sequencer.
- Adds an optional write-to-read bypass for pipelined datapaths.
- Sits between decode (register addresses) and execute (operands). Write-back drives the write port.

Parameters:
- DATA_W, 32, register data width in bits.
- DEPTH, 32, number of architectural registers (2..2**ADDR_W).
- ADDR_W, 5, register address width.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1, register 0 always reads 0 and writes to it are discarded.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- FR_WE  input  1  write enable.
- FR_Waddr  input  ADDR_W  write address.
- FR_Wdata  input  DATA_W  write data.
- FR_RAddr  input  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- FR_Rdata  output  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- FR_Busy  output  1  high while the clear sequencer runs; the file is not usable.
- FR_WrDrop  output  1  one-cycle pulse when a requested write was discarded.

Behaviour:
- Reset: rst asserted (asynchronous) forces state CLEAR, clr_cnt=0, FR_Busy=1, FR_WrDrop=0. FR_Rdata reads 0 on all ports while FR_Busy=1.
- Clear sequencer states:
  - CLEAR: each rising clk edge with rst low writes 0 to entry clr_cnt, then increments clr_cnt. When clr_cnt==DEPTH-1 is written, next state is READY.
  - FR_Busy falls exactly DEPTH clock edges after rst deasserts.
  - READY: normal operation; stays in READY until rst is asserted.
- Reset asserted mid-CLEAR restarts the sequence from entry 0. Reset in READY re-enters CLEAR.
- Writes are synchronous. On the rising edge in READY with FR_WE=1, entry FR_Waddr <= FR_Wdata.
- A write is discarded, and FR_WrDrop pulses high for the following cycle, when any of these hold:
  - state is CLEAR;
  - FR_Waddr >= DEPTH;
  - ZERO_REG=1 and FR_Waddr==0.
- FR_WrDrop is registered; it is 0 in any cycle without a discarded write.
- Reads are combinational and asynchronous, with zero-cycle latency from FR_RAddr.
- Read port k returns 0 when:
  - address >= DEPTH, or
  - ZERO_REG=1 and address==0, or
  - FR_Busy=1.
  Otherwise it returns the stored value.
- Same-cycle write and read of the same address without bypass: the read returns the old value. The new value is visible after the edge.
- Multiple read ports may address the same entry; each returns the identical value.
- The block has no file I/O and no initial-block preload. Contents are defined only by the clear sequencer and writes.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in READY, if FR_WE=1 and FR_Waddr equals read port k's address, port k returns FR_Wdata combinationally in the same cycle (write-first).
  - The zero-register, out-of-range and discarded-write rules take precedence: no bypass for address 0 when ZERO_REG=1, for address >= DEPTH, or during CLEAR.
- Undefined: reads return the stored (pre-edge) value; no forwarding logic is synthesised.

Test Plan:
- Reset clear: preload garbage by forcing writes before reset, pulse rst for 2 cycles. Required: FR_Busy=1 for exactly 32 edges after release, then 0, and all 32 registers read 0x00000000 on both ports.
- Basic write/read: write 0xDEADBEEF to r5 and 0x12345678 to r31, read r5 on port 0 and r31 on port 1. Required: both values returned the cycle after their writes; a same-cycle read of r5 returns the old value 0 (bypass off) or 0xDEADBEEF (REGFILE_BYPASS_EN).
- Zero register: write 0xFFFFFFFF to r0. Required: FR_WrDrop=1 on the next cycle and r0 reads 0 on all ports.
- Writes during clear: assert FR_WE to r3 with 0xAAAA5555 while FR_Busy=1. Required: FR_WrDrop pulses, reads return 0 during CLEAR, and r3 reads 0 after FR_Busy falls.
- Reset mid-clear: assert rst when clr_cnt=10. Required: FR_Busy stays 1 and falls exactly 32 edges after the second release.
- Parameter sweep: DEPTH=24, ADDR_W=5, NUM_RD=4, DATA_W=64. Write to address 27. Required: discarded with FR_WrDrop=1, reads of address 27 return 0, and all four ports return correct 64-bit data for r1..r23.

Source files
------------

// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised multi-read-port register file with an after-reset clear sequencer.
// Optional write-to-read forwarding is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       FR_WE,
    input  logic [ADDR_W-1:0]          FR_Waddr,
    input  logic [DATA_W-1:0]          FR_Wdata,
    input  logic [NUM_RD*ADDR_W-1:0]   FR_RAddr,
    output logic [NUM_RD*DATA_W-1:0]   FR_Rdata,
    output logic                       FR_Busy,
    output logic                       FR_WrDrop
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);
    localparam bit                ZERO_EN = (ZERO_REG != 0);

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_ok;
    logic                wr_drop;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    // An address is usable when it is in range and is not the hard-wired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !(ZERO_EN && (a == '0));
    endfunction

    assign wr_ok   = FR_WE && (state == READY) && addr_ok(FR_Waddr);
    assign wr_drop = FR_WE && !wr_ok;

    always_comb begin
        mem_we = 1'b0;
        mem_wa = clr_cnt;
        mem_wd = '0;
        if (state == CLEAR) begin
            mem_we = 1'b1;
        end else if (wr_ok) begin
            mem_we = 1'b1;
            mem_wa = FR_Waddr;
            mem_wd = FR_Wdata;
        end
    end

    // Storage has no reset of its own; the clear sequencer owns initialisation.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            FR_Busy   <= 1'b1;
            FR_WrDrop <= 1'b0;
        end else begin
            FR_WrDrop <= wr_drop;
            if (state == CLEAR) begin
                if (clr_cnt == LAST) begin
                    state   <= READY;
                    FR_Busy <= 1'b0;
                    clr_cnt <= '0;
                end else begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        ra       = '0;
        FR_Rdata = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra = FR_RAddr[k*ADDR_W +: ADDR_W];
            if (!FR_Busy && addr_ok(ra)) begin
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (FR_Waddr == ra)) begin
                    FR_Rdata[k*DATA_W +: DATA_W] = FR_Wdata;
                end else begin
                    FR_Rdata[k*DATA_W +: DATA_W] = mem[ra];
                end
`else
                FR_Rdata[k*DATA_W +: DATA_W] = mem[ra];
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: default 32x32 instance plus a 24x64, 4-read-port instance.
// Expected values are queued at drive time and popped when the DUT output is sampled.
module tb_regfile_multiport;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int NR  = 2;
    localparam int DW2 = 64;
    localparam int NR2 = 4;
    localparam int DP2 = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              we, we2;
    logic [AW-1:0]     waddr, waddr2;
    logic [DW-1:0]     wdata;
    logic [DW2-1:0]    wdata2;
    logic [NR*AW-1:0]  raddr;
    logic [NR2*AW-1:0] raddr2;
    logic [NR*DW-1:0]  rdata;
    logic [NR2*DW2-1:0] rdata2;
    logic              busy, busy2, drop, drop2;

    int checks = 0;
    int errors = 0;
    int n1, n2;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0]  model  [32];
    logic [DW2-1:0] model2 [DP2];

    always #5 clk = ~clk;

    regfile_multiport u_dut (
        .clk       (clk),
        .rst       (rst),
        .FR_WE     (we),
        .FR_Waddr  (waddr),
        .FR_Wdata  (wdata),
        .FR_RAddr  (raddr),
        .FR_Rdata  (rdata),
        .FR_Busy   (busy),
        .FR_WrDrop (drop)
    );

    regfile_multiport #(
        .DATA_W   (DW2),
        .DEPTH    (DP2),
        .ADDR_W   (AW),
        .NUM_RD   (NR2),
        .ZERO_REG (1)
    ) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .FR_WE     (we2),
        .FR_Waddr  (waddr2),
        .FR_Wdata  (wdata2),
        .FR_RAddr  (raddr2),
        .FR_Rdata  (rdata2),
        .FR_Busy   (busy2),
        .FR_WrDrop (drop2)
    );

    task automatic expect_v(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h with no queued expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic [63:0] rd1(input int k);
        return 64'(rdata[k*DW +: DW]);
    endfunction

    function automatic logic [63:0] rd2(input int k);
        return rdata2[k*DW2 +: DW2];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        waddr = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic wr2(input logic [AW-1:0] a, input logic [DW2-1:0] d);
        waddr2 = a;
        wdata2 = d;
        we2    = 1'b1;
        tick();
        we2    = 1'b0;
    endtask

    // Counts edges until each FR_Busy falls; 0 means it never fell within the budget.
    task automatic wait_ready(output int a, output int b);
        a = 0;
        b = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (a == 0 && !busy)  a = i;
            if (b == 0 && !busy2) b = i;
            if (a != 0 && b != 0) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; we = 1'b0; we2 = 1'b0;
        waddr = '0; wdata = '0; waddr2 = '0; wdata2 = '0;
        raddr = '0; raddr2 = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset state
        repeat (2) tick();
        expect_v("rst_busy", 64'd1);    check(64'(busy));
        expect_v("rst_busy2", 64'd1);   check(64'(busy2));
        expect_v("rst_wrdrop", 64'd0);  check(64'(drop));
        raddr = {AW'(31), AW'(5)};
        #1;
        expect_v("rst_rd_p0", 64'd0);   check(rd1(0));
        expect_v("rst_rd_p1", 64'd0);   check(rd1(1));
        rst = 1'b0;
        wait_ready(n1, n2);
        expect_v("busy_edges", 64'd32);  check(64'(n1));
        expect_v("busy_edges2", 64'd24); check(64'(n2));

        // Garbage preload then a 2-cycle reset pulse
        for (int i = 0; i < 32; i++) wr(AW'(i), $urandom | 32'h1);
        rst = 1'b1;
        tick();
        expect_v("rst2_busy", 64'd1); check(64'(busy));
        tick();
        rst = 1'b0;
        wait_ready(n1, n2);
        expect_v("busy_edges_rst2", 64'd32); check(64'(n1));
        for (int i = 0; i < 32; i++) begin
            raddr = {AW'(31 - i), AW'(i)};
            #1;
            expect_v($sformatf("clr_p0_r%0d", i), 64'd0); check(rd1(0));
            expect_v($sformatf("clr_p1_r%0d", 31 - i), 64'd0); check(rd1(1));
        end

        // Basic write/read with same-cycle read of r5
        raddr = {AW'(31), AW'(5)};
        waddr = 5; wdata = 32'hDEADBEEF; we = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        expect_v("same_cycle_r5", 64'hDEADBEEF);
`else
        expect_v("same_cycle_r5", 64'd0);
`endif
        check(rd1(0));
        tick();
        waddr = 31; wdata = 32'h12345678;
        #1;
        expect_v("r5_after_write", 64'hDEADBEEF); check(rd1(0));
`ifdef REGFILE_BYPASS_EN
        expect_v("same_cycle_r31", 64'h12345678);
`else
        expect_v("same_cycle_r31", 64'd0);
`endif
        check(rd1(1));
        tick();
        we = 1'b0;
        model[5] = 32'hDEADBEEF;
        model[31] = 32'h12345678;
        expect_v("wrdrop_valid_write", 64'd0); check(64'(drop));
        expect_v("r31_after_write", 64'h12345678); check(rd1(1));
        raddr = {AW'(5), AW'(5)};
        #1;
        expect_v("dual_r5_p0", 64'hDEADBEEF); check(rd1(0));
        expect_v("dual_r5_p1", 64'hDEADBEEF); check(rd1(1));

        // Zero register
        raddr = '0;
        waddr = 0; wdata = 32'hFFFFFFFF; we = 1'b1;
        #1;
        expect_v("r0_same_cycle", 64'd0); check(rd1(0));
        tick();
        we = 1'b0;
        expect_v("r0_wrdrop", 64'd1); check(64'(drop));
        expect_v("r0_p0", 64'd0);     check(rd1(0));
        expect_v("r0_p1", 64'd0);     check(rd1(1));
        tick();
        expect_v("r0_wrdrop_clear", 64'd0); check(64'(drop));

        // Random traffic against the model
        for (int i = 0; i < 12; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            a = AW'($urandom_range(31, 1));
            d = $urandom;
            model[a] = d;
            wr(a, d);
        end
        for (int i = 0; i < 32; i++) begin
            raddr = {AW'(31 - i), AW'(i)};
            #1;
            expect_v($sformatf("model_p0_r%0d", i), 64'(model[i])); check(rd1(0));
            expect_v($sformatf("model_p1_r%0d", 31 - i), 64'(model[31 - i])); check(rd1(1));
        end

        // Writes during clear, then reset at clr_cnt==10
        rst = 1'b1;
        tick();
        rst = 1'b0;
        waddr = 3; wdata = 32'hAAAA5555; we = 1'b1;
        raddr = {AW'(3), AW'(3)};
        #1;
        expect_v("clear_rd_r3", 64'd0); check(rd1(0));
        tick();
        we = 1'b0;
        expect_v("clear_wrdrop", 64'd1); check(64'(drop));
        expect_v("clear_busy", 64'd1);   check(64'(busy));
        expect_v("clear_rd_r3_b", 64'd0); check(rd1(1));
        tick();
        expect_v("clear_wrdrop_end", 64'd0); check(64'(drop));
        repeat (8) tick();
        expect_v("busy_at_cnt10", 64'd1); check(64'(busy));
        rst = 1'b1;
        tick();
        expect_v("busy_mid_rst", 64'd1); check(64'(busy));
        rst = 1'b0;
        wait_ready(n1, n2);
        expect_v("busy_edges_restart", 64'd32);  check(64'(n1));
        expect_v("busy_edges_restart2", 64'd24); check(64'(n2));
        raddr = {AW'(5), AW'(3)};
        #1;
        expect_v("r3_after_clear", 64'd0); check(rd1(0));
        expect_v("r5_after_clear", 64'd0); check(rd1(1));

        // Wide, 4-port, 24-entry instance
        wr2(27, 64'hCAFEF00D_0BADBEEF);
        expect_v("p2_wrdrop_oor", 64'd1); check(64'(drop2));
        for (int k = 0; k < NR2; k++) raddr2[k*AW +: AW] = AW'(27);
        #1;
        for (int k = 0; k < NR2; k++) begin
            expect_v($sformatf("p2_r27_p%0d", k), 64'd0); check(rd2(k));
        end
        for (int i = 1; i < DP2; i++) begin
            model2[i] = {$urandom, $urandom};
            wr2(AW'(i), model2[i]);
        end
        expect_v("p2_wrdrop_valid", 64'd0); check(64'(drop2));
        for (int i = 1; i < DP2; i++) begin
            for (int k = 0; k < NR2; k++) raddr2[k*AW +: AW] = AW'(((i - 1 + k * 5) % 23) + 1);
            #1;
            for (int k = 0; k < NR2; k++) begin
                expect_v($sformatf("p2_rd_p%0d_i%0d", k, i), model2[((i - 1 + k * 5) % 23) + 1]);
                check(rd2(k));
            end
        end
        raddr2 = {AW'(31), AW'(23), AW'(0), AW'(24)};
        #1;
        expect_v("p2_r24", 64'd0);            check(rd2(0));
        expect_v("p2_r0", 64'd0);             check(rd2(1));
        expect_v("p2_r23", model2[23]);       check(rd2(2));
        expect_v("p2_r31", 64'd0);            check(rd2(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
